// File: rtl/permutation_multi_round.sv
// ---------------------------------------------------------------------------
// permutation_multi_round
//
// Iterative Ascon-p permutation engine. A run applies rounds 12-n .. 11
// (constant add, 5-bit S-box layer, linear diffusion) to a 320-bit state,
// UNROLL rounds per clock, with an internal round index and a
// start/done handshake.
//
// State layout: x0 = [319:256], x1 = [255:192], x2 = [191:128],
//               x3 = [127:64],  x4 = [63:0].
//
// Parameters:
//   UNROLL        rounds per clock, one of {1,2,3,4,6,12}
//
// Ports:
//   clock         in   1    system clock, rising edge
//   reset_n       in   1    asynchronous reset, active low
//   i_sys_enable  in   1    low = synchronous soft reset
//   i_abort       in   1    (PERMUTATION_ABORT_EN only) abort a running permutation
//   i_start       in   1    request a permutation, sampled only in IDLE
//   i_num_rounds  in   4    round count n (1..12, multiple of UNROLL)
//   i_state       in   320  input state, sampled with i_start
//   o_busy        out  1    high while rounds are executing
//   o_done        out  1    one-cycle pulse, o_state holds the result
//   o_error       out  1    one-cycle pulse, illegal round count dropped
//   o_state       out  320  result register
//
// Configuration macro: PERMUTATION_ABORT_EN adds the i_abort input.
// ---------------------------------------------------------------------------
module permutation_multi_round #(
  parameter int UNROLL = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         i_sys_enable,
`ifdef PERMUTATION_ABORT_EN
  input  logic         i_abort,
`endif
  input  logic         i_start,
  input  logic [3:0]   i_num_rounds,
  input  logic [319:0] i_state,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_error,
  output logic [319:0] o_state
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 ||
        UNROLL == 4 || UNROLL == 6 || UNROLL == 12)) begin : g_bad_unroll
    $error("permutation_multi_round: UNROLL must be one of 1,2,3,4,6,12");
  end

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } t_fsm;

  // Rotate a 64-bit lane right by a constant amount.
  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    logic [127:0] w_dbl;
    w_dbl = {x, x} >> n;
    return w_dbl[63:0];
  endfunction

  // One Ascon-p round with absolute round index idx.
  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] idx);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    x0 = s[319:256];
    x1 = s[255:192];
    x2 = s[191:128];
    x3 = s[127:64];
    x4 = s[63:0];
    // Round constant {F-i, i} lands in the low byte of x2.
    x2 = x2 ^ {56'd0, 4'hF - idx, idx};
    // Bit-sliced 5-bit S-box across all 64 columns.
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    // Linear diffusion, one rotation pair per lane.
    x0 = x0 ^ ror64(x0, 32'd19) ^ ror64(x0, 32'd28);
    x1 = x1 ^ ror64(x1, 32'd61) ^ ror64(x1, 32'd39);
    x2 = x2 ^ ror64(x2, 32'd1)  ^ ror64(x2, 32'd6);
    x3 = x3 ^ ror64(x3, 32'd10) ^ ror64(x3, 32'd17);
    x4 = x4 ^ ror64(x4, 32'd7)  ^ ror64(x4, 32'd41);
    return {x0, x1, x2, x3, x4};
  endfunction

  t_fsm         r_fsm;
  logic [3:0]   r_idx;
  logic [319:0] r_state;
  logic         r_busy;
  logic         r_done;
  logic         r_error;

  t_fsm         w_fsm_nxt;
  logic [3:0]   w_idx_nxt;
  logic [319:0] w_state_nxt;
  logic         w_busy_nxt;
  logic         w_done_nxt;
  logic         w_error_nxt;

  logic [319:0] w_base_state;
  logic [3:0]   w_base_idx;
  logic [3:0]   w_chain_idx;
  logic [319:0] w_chain;
  logic         w_legal;
  logic         w_abort;

`ifdef PERMUTATION_ABORT_EN
  assign w_abort = i_abort;
`else
  assign w_abort = 1'b0;
`endif

  // Round count legality: 1..12 and a whole number of clock steps.
  assign w_legal = (i_num_rounds >= 4'd1) && (i_num_rounds <= 4'd12) &&
                   ((int'(i_num_rounds) % UNROLL) == 0);

  // Datapath source: fresh input in IDLE, working register in RUN.
  always_comb begin
    if (r_fsm == ST_IDLE) begin
      w_base_state = i_state;
      w_base_idx   = 4'd12 - i_num_rounds;
    end else begin
      w_base_state = r_state;
      w_base_idx   = r_idx;
    end
  end

  // UNROLL chained rounds per clock and the index they leave behind.
  always_comb begin
    w_chain     = w_base_state;
    w_chain_idx = w_base_idx;
    for (int k = 0; k < UNROLL; k++) begin
      w_chain     = ascon_round(w_chain, w_chain_idx);
      w_chain_idx = w_chain_idx + 4'd1;
    end
  end

  // Next-state and registered-output logic of the round sequencer.
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_idx_nxt   = r_idx;
    w_state_nxt = r_state;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_error_nxt = 1'b0;
    case (r_fsm)
      ST_IDLE: begin
        if (i_start) begin
          if (w_legal) begin
            w_state_nxt = w_chain;
            // A run of exactly UNROLL rounds finishes on its first edge.
            if (w_chain_idx == 4'd12) begin
              w_done_nxt = 1'b1;
              w_idx_nxt  = 4'd0;
            end else begin
              w_fsm_nxt  = ST_RUN;
              w_idx_nxt  = w_chain_idx;
              w_busy_nxt = 1'b1;
            end
          end else begin
            w_error_nxt = 1'b1;
          end
        end else begin
          w_error_nxt = 1'b0;
        end
      end
      ST_RUN: begin
        if (w_abort) begin
          // Abort keeps the partial state; no further rounds are applied.
          w_fsm_nxt = ST_IDLE;
          w_idx_nxt = 4'd0;
        end else begin
          w_state_nxt = w_chain;
          if (w_chain_idx == 4'd12) begin
            w_fsm_nxt  = ST_IDLE;
            w_idx_nxt  = 4'd0;
            w_done_nxt = 1'b1;
          end else begin
            w_idx_nxt  = w_chain_idx;
            w_busy_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_fsm_nxt = ST_IDLE;
        w_idx_nxt = 4'd0;
      end
    endcase
  end

  // Sequencer and result registers with async and soft reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fsm   <= ST_IDLE;
      r_idx   <= 4'd0;
      r_state <= 320'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else if (!i_sys_enable) begin
      r_fsm   <= ST_IDLE;
      r_idx   <= 4'd0;
      r_state <= 320'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_idx   <= w_idx_nxt;
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_error <= w_error_nxt;
    end
  end

  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_error = r_error;
  assign o_state = r_state;

endmodule

// File: tb/tb_permutation_multi_round.sv
module tb_permutation_multi_round;

  logic         clock;
  logic         reset_n;
  logic         en    [2];
  logic         start [2];
  logic [3:0]   nr    [2];
  logic [319:0] sin   [2];
  logic         busy  [2];
  logic         done  [2];
  logic         err   [2];
  logic [319:0] sout  [2];
`ifdef PERMUTATION_ABORT_EN
  logic         abort [2];
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam int RA [5] = '{19, 61, 1, 10, 7};
  localparam int RB [5] = '{28, 39, 6, 17, 41};
  localparam int UN [2] = '{1, 2};

  permutation_multi_round #(.UNROLL(1)) u1 (
    .clock(clock), .reset_n(reset_n), .i_sys_enable(en[0]),
`ifdef PERMUTATION_ABORT_EN
    .i_abort(abort[0]),
`endif
    .i_start(start[0]), .i_num_rounds(nr[0]), .i_state(sin[0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_error(err[0]), .o_state(sout[0]));

  permutation_multi_round #(.UNROLL(2)) u2 (
    .clock(clock), .reset_n(reset_n), .i_sys_enable(en[1]),
`ifdef PERMUTATION_ABORT_EN
    .i_abort(abort[1]),
`endif
    .i_start(start[1]), .i_num_rounds(nr[1]), .i_state(sin[1]),
    .o_busy(busy[1]), .o_done(done[1]), .o_error(err[1]), .o_state(sout[1]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Reference: rounds first..first+count-1 using the S-box table column by column.
  function automatic logic [319:0] model(input logic [319:0] s, input int first, input int count);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  col;
    logic [4:0]  sb;
    for (int w = 0; w < 5; w++) x[w] = s[319 - 64*w -: 64];
    for (int r = first; r < first + count; r++) begin
      x[2] = x[2] ^ 64'((15 - r) * 16 + r);
      for (int j = 0; j < 64; j++) begin
        col = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
        sb  = SBOX[col];
        for (int w = 0; w < 5; w++) y[w][j] = sb[4 - w];
      end
      for (int w = 0; w < 5; w++) x[w] = y[w] ^ ror(y[w], RA[w]) ^ ror(y[w], RB[w]);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic logic [319:0] rnd_state();
    logic [319:0] v;
    for (int i = 0; i < 10; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Called at a negedge; issues a one-cycle start and returns at the following negedge.
  task automatic issue(input int d, input logic [3:0] n, input logic [319:0] s);
    start[d] = 1'b1;
    nr[d]    = n;
    sin[d]   = s;
    @(posedge clock);
    @(negedge clock);
    start[d] = 1'b0;
  endtask

  // Cycles from the start edge to the negedge where done is seen (1 = right after it).
  task automatic wait_done(input int d, input int limit, output int lat);
    lat = 1;
    while (!done[d] && lat < limit) begin
      @(negedge clock);
      lat++;
    end
    if (!done[d]) lat = -1;
  endtask

  task automatic run_legal(input string name, input int d, input logic [3:0] n, input logic [319:0] s);
    int lat;
    int nn;
    nn = int'(n);
    issue(d, n, s);
    wait_done(d, nn / UN[d] + 8, lat);
    check({name, "_latency"}, 320'(lat), 320'(nn / UN[d]));
    check({name, "_state"}, sout[d], model(s, 12 - nn, nn));
    check({name, "_busy_at_done"}, 320'(busy[d]), 320'd0);
  endtask

  task automatic run_illegal(input string name, input int d, input logic [3:0] n, input logic [319:0] s);
    logic [319:0] prev;
    prev = sout[d];
    issue(d, n, s);
    check({name, "_err"}, 320'(err[d]), 320'd1);
    check({name, "_busy"}, 320'(busy[d]), 320'd0);
    check({name, "_state_kept"}, sout[d], prev);
    @(negedge clock);
    check({name, "_err_pulse"}, 320'(err[d]), 320'd0);
    check({name, "_busy2"}, 320'(busy[d]), 320'd0);
  endtask

  typedef struct {
    int         d;
    logic [3:0] n;
    bit         legal;
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic [319:0] sa;
    logic [319:0] sb2;
    int lat;
    int dcount;
    int first_done;
    int d;
    logic [3:0] n;

    tbl = '{
      '{1, 4'd0, 1'b0},  '{1, 4'd5, 1'b0},  '{1, 4'd13, 1'b0}, '{1, 4'd15, 1'b0},
      '{1, 4'd1, 1'b0},  '{1, 4'd11, 1'b0}, '{1, 4'd2, 1'b1},  '{1, 4'd4, 1'b1},
      '{1, 4'd6, 1'b1},  '{1, 4'd12, 1'b1}, '{0, 4'd1, 1'b1},  '{0, 4'd7, 1'b1},
      '{0, 4'd12, 1'b1}, '{0, 4'd0, 1'b0},  '{0, 4'd13, 1'b0}, '{0, 4'd14, 1'b0}};

    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b1; start[i] = 1'b0; nr[i] = 4'd0; sin[i] = 320'd0;
`ifdef PERMUTATION_ABORT_EN
      abort[i] = 1'b0;
`endif
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      check("reset_busy", 320'(busy[i]), 320'd0);
      check("reset_done", 320'(done[i]), 320'd0);
      check("reset_err", 320'(err[i]), 320'd0);
      check("reset_state", sout[i], 320'd0);
    end

    // Ascon IV with zero key/nonce, full 12 rounds on UNROLL=1.
    run_legal("iv12", 0, 4'd12, {64'h80400c0600000000, 256'd0});

    // Table of round counts for both instances.
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].legal) run_legal($sformatf("tbl%0d", i), tbl[i].d, tbl[i].n, rnd_state());
      else              run_illegal($sformatf("tbl%0d", i), tbl[i].d, tbl[i].n, rnd_state());
    end

    // Randomized legal runs against the model.
    for (int i = 0; i < 16; i++) begin
      d = int'($urandom_range(0, 1));
      n = 4'(UN[d] * int'($urandom_range(1, 12 / UN[d])));
      run_legal($sformatf("rnd%0d", i), d, n, rnd_state());
    end

    // Back-to-back on UNROLL=2: n=6, then n=12 issued in the done cycle.
    sa  = rnd_state();
    sb2 = rnd_state();
    issue(1, 4'd6, sa);
    wait_done(1, 10, lat);
    check("b2b_lat1", 320'(lat), 320'd3);
    check("b2b_state1", sout[1], model(sa, 6, 6));
    issue(1, 4'd12, sb2);
    check("b2b_busy_no_gap", 320'(busy[1]), 320'd1);
    wait_done(1, 14, lat);
    check("b2b_lat2", 320'(lat), 320'd6);
    check("b2b_state2", sout[1], model(sb2, 0, 12));

    // Starts during a run are ignored.
    sa = rnd_state();
    issue(0, 4'd12, sa);
    dcount = 0;
    first_done = -1;
    for (int c = 1; c <= 20; c++) begin
      start[0] = (c == 3 || c == 5);
      if (c == 3 || c == 5) begin
        nr[0] = 4'd4;
        sin[0] = rnd_state();
      end
      if (done[0]) begin
        dcount++;
        if (first_done < 0) first_done = c;
        if (dcount == 1) check("ign_state", sout[0], model(sa, 0, 12));
      end
      @(negedge clock);
      start[0] = 1'b0;
    end
    check("ign_done_count", 320'(dcount), 320'd1);
    check("ign_done_cycle", 320'(first_done), 320'd12);

    // Asynchronous reset mid-run.
    issue(0, 4'd12, rnd_state());
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("arst_state", sout[0], 320'd0);
    check("arst_busy", 320'(busy[0]), 320'd0);
    @(negedge clock);
    reset_n = 1'b1;
    dcount = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clock);
      if (done[0]) dcount++;
    end
    check("arst_no_done", 320'(dcount), 320'd0);
    run_legal("arst_clean", 0, 4'd12, rnd_state());

    // Soft reset mid-run.
    issue(0, 4'd12, rnd_state());
    repeat (3) @(negedge clock);
    en[0] = 1'b0;
    @(negedge clock);
    en[0] = 1'b1;
    check("srst_state", sout[0], 320'd0);
    check("srst_busy", 320'(busy[0]), 320'd0);
    dcount = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clock);
      if (done[0]) dcount++;
    end
    check("srst_no_done", 320'(dcount), 320'd0);
    run_legal("srst_clean", 0, 4'd12, rnd_state());

`ifdef PERMUTATION_ABORT_EN
    // Abort after six rounds keeps the partial state.
    sa = rnd_state();
    issue(0, 4'd12, sa);
    repeat (5) @(negedge clock);
    abort[0] = 1'b1;
    @(negedge clock);
    abort[0] = 1'b0;
    check("abort_busy", 320'(busy[0]), 320'd0);
    check("abort_state", sout[0], model(sa, 0, 6));
    dcount = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clock);
      if (done[0]) dcount++;
    end
    check("abort_no_done", 320'(dcount), 320'd0);
    check("abort_state_held", sout[0], model(sa, 0, 6));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
